// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM encoding and counter sizing.
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Single 1-bit full-adder cell, time-shared by the serial sequencer.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell walked LSB-first over WIDTH cycles,
// with a start/busy/done handshake and a result held until the next accepted start.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sr, b_sr, sum_q;
  logic             carry_q, cout_q;
  logic             fa_s, fa_co;
  logic             accept;

  fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // A start is only honoured when idle or finishing; in RUN it is dropped.
  assign accept = ena && start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d = state_q;
    if (ena) begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (cnt_q == LAST) state_d = DONE;
        DONE:    state_d = start ? RUN : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      if (accept) begin
        a_sr    <= a;
        b_sr    <= b;
        carry_q <= cin;
        cnt_q   <= '0;
        sum_q   <= '0;
        cout_q  <= 1'b0;
      end else if (state_q == RUN) begin
        // Result bits enter at the MSB so that after WIDTH shifts they sit in natural order.
        sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
        a_sr    <= a_sr >> 1;
        b_sr    <= b_sr >> 1;
        carry_q <= fa_co;
        cnt_q   <= cnt_q + 1'b1;
        if (cnt_q == LAST) cout_q <= fa_co;
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of the bit-serial adder sequencer at WIDTH=8.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n, ena, start, cin;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;

  int checks = 0;
  int failures = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept an op, then wait (bounded) for done; reports edges taken after the accept edge.
  task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv,
                       output int edges);
    a = av; b = bv; cin = cv; start = 1'b1;
    step();
    start = 1'b0;
    edges = 0;
    while (!done && edges < 40) begin
      step();
      edges++;
    end
    check("done_timeout", {63'd0, done}, 64'd1);
  endtask

  initial begin
    int edges;
    int ndone;
    logic [WIDTH:0] expv;

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    step(); step();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_sum",  {56'd0, sum},  64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    rst_n = 1'b1;
    step();

    // 1: busy for exactly 8 cycles, done after the 8th RUN edge
    a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      check($sformatf("t1_busy%0d", i), {63'd0, busy}, 64'd1);
      step();
    end
    check("t1_busy_end", {63'd0, busy}, 64'd0);
    check("t1_done", {63'd0, done}, 64'd1);
    check("t1_sum",  {56'd0, sum},  64'h8D);
    check("t1_cout", {63'd0, cout}, 64'd0);
    step();
    check("t1_done_pulse", {63'd0, done}, 64'd0);

    // 2: carry out, then carry in
    do_op(8'hFF, 8'h01, 1'b0, edges);
    check("t2a_lat",  edges, 64'd8);
    check("t2a_sum",  {56'd0, sum},  64'h00);
    check("t2a_cout", {63'd0, cout}, 64'd1);
    step();
    do_op(8'h00, 8'h00, 1'b1, edges);
    check("t2b_sum",  {56'd0, sum},  64'h01);
    check("t2b_cout", {63'd0, cout}, 64'd0);
    step();

    // 3: start during RUN is ignored
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        ndone++;
        check("t3_sum",  {56'd0, sum},  64'h30);
        check("t3_cout", {63'd0, cout}, 64'd0);
      end
      step();
    end
    check("t3_ndone", ndone, 64'd1);

    // 4: ena low for 3 cycles mid-RUN stretches latency by 3
    a = 8'h7F; b = 8'h7F; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t4_frz_busy%0d", i), {63'd0, busy}, 64'd1);
    end
    ena = 1'b1;
    edges = 7;
    while (!done && edges < 40) begin
      step();
      edges++;
    end
    check("t4_lat",  edges, 64'd11);
    check("t4_sum",  {56'd0, sum},  64'hFF);
    check("t4_cout", {63'd0, cout}, 64'd0);
    step();

    // 5: reset mid-RUN aborts with no done
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    check("t5_busy", {63'd0, busy}, 64'd0);
    check("t5_done", {63'd0, done}, 64'd0);
    check("t5_sum",  {56'd0, sum},  64'd0);
    check("t5_cout", {63'd0, cout}, 64'd0);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) ndone++;
    end
    check("t5_ndone", ndone, 64'd0);

    // 6: start held high gives back-to-back ops every 9 cycles
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    step();
    a = 8'h80; b = 8'h80;
    for (int i = 0; i < WIDTH; i++) step();
    check("t6a_done", {63'd0, done}, 64'd1);
    check("t6a_sum",  {56'd0, sum},  64'h03);
    check("t6a_cout", {63'd0, cout}, 64'd0);
    for (int i = 0; i < WIDTH; i++) step();
    check("t6_gap", {63'd0, done}, 64'd0);
    step();
    check("t6b_done", {63'd0, done}, 64'd1);
    check("t6b_sum",  {56'd0, sum},  64'h00);
    check("t6b_cout", {63'd0, cout}, 64'd1);
    start = 1'b0;
    step(); step();

    // Random scoreboard
    for (int n = 0; n < 1000; n++) begin
      logic [WIDTH-1:0] ra, rb;
      logic rc;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      expv = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
      do_op(ra, rb, rc, edges);
      check($sformatf("rnd%0d", n), {55'd0, cout, sum}, {55'd0, expv});
      if (n % 3 == 0) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
